// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 5..DATA_W data bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_HOLD_EN to add a one-word holding register for gapless back-to-back frames.
module uart_tx_engine #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic [3:0]        data_len,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              two_stop,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [3:0]       LP_MAX_LEN = 4'(DATA_W);
   localparam logic [DIV_W-1:0] LP_CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } state_t;

   function automatic logic [3:0] f_eff_len(input logic [3:0] len);
      logic [3:0] l;
      if (len < 4'd5) begin
         l = 4'd5;
      end else if (len > LP_MAX_LEN) begin
         l = LP_MAX_LEN;
      end else begin
         l = len;
      end
      return l;
   endfunction

   // Parity over the first len bits only; starts at 1 for odd sense.
   function automatic logic f_parity(input logic [DATA_W-1:0] d, input logic [3:0] len,
                                     input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < DATA_W; i++) begin
         if (4'(i) < len) begin
            p = p ^ d[i];
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

   state_t            r_state;
   logic [DIV_W-1:0]  r_cnt;
   logic [3:0]        r_bit_idx;
   logic [DATA_W-1:0] r_shift;
   logic [DIV_W-1:0]  r_div;
   logic [3:0]        r_len;
   logic              r_par_en;
   logic              r_par_bit;
   logic              r_two_stop;
   logic              r_tx;
   logic              r_busy;
   logic              r_frame_done;

   state_t            w_state_nxt;
   logic [DIV_W-1:0]  w_cnt_nxt;
   logic [3:0]        w_idx_nxt;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              w_tx_nxt;
   logic              w_done_nxt;
   logic              w_tx_ready;
   logic              w_accept;
   logic              w_bit_end;
   logic              w_final_edge;
   logic              w_word_avail;
   logic              w_hold_avail;
   logic              w_hold_vld_nxt;
   logic              w_load;
   logic [DATA_W-1:0] w_src_data;
   logic [DIV_W-1:0]  w_src_div;
   logic [3:0]        w_src_len;
   logic              w_src_pen;
   logic              w_src_podd;
   logic              w_src_two;

`ifdef UART_TX_HOLD_EN
   logic              r_hold_vld;
   logic [DATA_W-1:0] r_hold_data;
   logic [DIV_W-1:0]  r_hold_div;
   logic [3:0]        r_hold_len;
   logic              r_hold_pen;
   logic              r_hold_podd;
   logic              r_hold_two;
   logic              w_hold_take;
   logic              w_hold_put;

   assign w_tx_ready     = ~rst & ~r_hold_vld;
   assign w_hold_avail   = r_hold_vld;
   assign w_hold_take    = w_load & r_hold_vld;
   // An accepted word parks in the holding register unless it starts a frame on this edge.
   assign w_hold_put     = w_accept & ~(w_load & ~r_hold_vld);
   assign w_hold_vld_nxt = w_hold_put | (r_hold_vld & ~w_hold_take);
   assign w_src_data     = r_hold_vld ? r_hold_data : tx_data;
   assign w_src_div      = r_hold_vld ? r_hold_div  : baud_div;
   assign w_src_len      = r_hold_vld ? r_hold_len  : data_len;
   assign w_src_pen      = r_hold_vld ? r_hold_pen  : parity_en;
   assign w_src_podd     = r_hold_vld ? r_hold_podd : parity_odd;
   assign w_src_two      = r_hold_vld ? r_hold_two  : two_stop;

   // Holding register: captures word and format on acceptance, empties when the shifter takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_vld  <= 1'b0;
         r_hold_data <= {DATA_W{1'b0}};
         r_hold_div  <= {DIV_W{1'b0}};
         r_hold_len  <= 4'd0;
         r_hold_pen  <= 1'b0;
         r_hold_podd <= 1'b0;
         r_hold_two  <= 1'b0;
      end else begin
         r_hold_vld <= w_hold_vld_nxt;
         if (w_hold_put) begin
            r_hold_data <= tx_data;
            r_hold_div  <= baud_div;
            r_hold_len  <= data_len;
            r_hold_pen  <= parity_en;
            r_hold_podd <= parity_odd;
            r_hold_two  <= two_stop;
         end
      end
   end
`else
   assign w_tx_ready     = ~rst & (r_state == ST_IDLE);
   assign w_hold_avail   = 1'b0;
   assign w_hold_vld_nxt = 1'b0;
   assign w_src_data     = tx_data;
   assign w_src_div      = baud_div;
   assign w_src_len      = data_len;
   assign w_src_pen      = parity_en;
   assign w_src_podd     = parity_odd;
   assign w_src_two      = two_stop;
`endif

   assign w_accept     = tx_valid & w_tx_ready;
   assign w_bit_end    = (r_cnt == {DIV_W{1'b0}});
   assign w_word_avail = w_accept | w_hold_avail;
   assign w_final_edge = w_bit_end & (((r_state == ST_STOP1) & ~r_two_stop) | (r_state == ST_STOP2));
   assign w_load       = w_word_avail & ((r_state == ST_IDLE) | w_final_edge);
   assign w_done_nxt   = (w_cnt_nxt == {DIV_W{1'b0}}) &
                         ((w_state_nxt == ST_STOP2) | ((w_state_nxt == ST_STOP1) & ~r_two_stop));

   // Next-state, bit timer, shifter and next line level
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      if (w_load) begin
         w_state_nxt = ST_START;
         w_cnt_nxt   = w_src_div;
         w_idx_nxt   = 4'd0;
         w_shift_nxt = w_src_data;
         w_tx_nxt    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_tx_nxt = 1'b1;
            end
            ST_START: begin
               if (w_bit_end) begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = r_div;
                  w_idx_nxt   = 4'd0;
                  w_tx_nxt    = r_shift[0];
               end else begin
                  w_cnt_nxt = r_cnt - LP_CNT_ONE;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  w_cnt_nxt = r_div;
                  if (r_bit_idx == (r_len - 4'd1)) begin
                     if (r_par_en) begin
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_par_bit;
                     end else begin
                        w_state_nxt = ST_STOP1;
                        w_tx_nxt    = 1'b1;
                     end
                  end else begin
                     w_idx_nxt   = r_bit_idx + 4'd1;
                     w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                     w_tx_nxt    = r_shift[1];
                  end
               end else begin
                  w_cnt_nxt = r_cnt - LP_CNT_ONE;
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  w_state_nxt = ST_STOP1;
                  w_cnt_nxt   = r_div;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - LP_CNT_ONE;
               end
            end
            ST_STOP1: begin
               if (w_bit_end) begin
                  w_state_nxt = r_two_stop ? ST_STOP2 : ST_IDLE;
                  w_cnt_nxt   = r_two_stop ? r_div : {DIV_W{1'b0}};
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - LP_CNT_ONE;
               end
            end
            ST_STOP2: begin
               if (w_bit_end) begin
                  w_state_nxt = ST_IDLE;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - LP_CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = {DIV_W{1'b0}};
               w_tx_nxt    = 1'b1;
            end
         endcase
      end
   end

   // Frame state, latched frame format, line driver and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= {DIV_W{1'b0}};
         r_bit_idx    <= 4'd0;
         r_shift      <= {DATA_W{1'b0}};
         r_div        <= {DIV_W{1'b0}};
         r_len        <= 4'd0;
         r_par_en     <= 1'b0;
         r_par_bit    <= 1'b0;
         r_two_stop   <= 1'b0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bit_idx    <= w_idx_nxt;
         r_shift      <= w_shift_nxt;
         r_tx         <= w_tx_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE) | w_hold_vld_nxt;
         r_frame_done <= w_done_nxt;
         if (w_load) begin
            r_div      <= w_src_div;
            r_len      <= f_eff_len(w_src_len);
            r_par_en   <= w_src_pen;
            r_par_bit  <= f_parity(w_src_data, f_eff_len(w_src_len), w_src_podd);
            r_two_stop <= w_src_two;
         end
      end
   end

   assign tx_ready   = w_tx_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule
